// File: rtl/trace_sched_pkg.sv
// Shared types and widths for the wallet trace scheduler.
package trace_sched_pkg;

   localparam int unsigned TS_W    = 31;
   localparam int unsigned VAL_W   = 20;
   localparam int unsigned METH_W  = 2;
   localparam int unsigned SCORE_W = 7;
   localparam int unsigned CNT_W   = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      REPORT = 2'd3
   } state_t;

   // One offered transaction from a requester.
   typedef struct packed {
      logic [TS_W-1:0]   ts;
      logic              dir_in;
      logic [METH_W-1:0] method;
      logic [VAL_W-1:0]  value;
      logic              last;
   } req_tx_t;

endpackage

// File: rtl/trace_scheduler_if.sv
// Requester, engine and result signals of the trace scheduler.
interface trace_scheduler_if;
   import trace_sched_pkg::*;

   logic                req_valid_0;
   logic                req_valid_1;
   logic                req_ready_0;
   logic                req_ready_1;
   req_tx_t             req_0;
   req_tx_t             req_1;

   logic                eng_valid;
   logic [TS_W-1:0]     eng_time_stamp;
   logic                eng_in;
   logic [METH_W-1:0]   eng_method_field;
   logic [VAL_W-1:0]    eng_value;
   logic                eng_new_wallet;
   logic [SCORE_W-1:0]  eng_confidence_score;

   logic                res_valid;
   logic                res_ready;
   logic                res_id;
   logic [SCORE_W-1:0]  res_score;
   logic [CNT_W-1:0]    res_count;
   logic                res_trunc;
   logic                res_order_err;

   // Environment side: offers transactions, supplies scores, consumes results.
   modport master (
      output req_valid_0, req_valid_1, req_0, req_1, eng_confidence_score, res_ready,
      input  req_ready_0, req_ready_1, eng_valid, eng_time_stamp, eng_in,
             eng_method_field, eng_value, eng_new_wallet,
             res_valid, res_id, res_score, res_count, res_trunc, res_order_err
   );

   // Scheduler side.
   modport slave (
      input  req_valid_0, req_valid_1, req_0, req_1, eng_confidence_score, res_ready,
      output req_ready_0, req_ready_1, eng_valid, eng_time_stamp, eng_in,
             eng_method_field, eng_value, eng_new_wallet,
             res_valid, res_id, res_score, res_count, res_trunc, res_order_err
   );

endinterface

// File: rtl/trace_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer requester wins ties.
module trace_rr_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       served_id,
   output logic       grant_id_c
);

   logic ptr;

   // After a served trace the other requester gets priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (advance) begin
         ptr <= ~served_id;
      end
   end

   assign grant_id_c = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/trace_scheduler.sv
// Streams one requester's wallet trace at a time into the tracing engine
// and reports the captured confidence score with trace statistics.
module trace_scheduler
   import trace_sched_pkg::*;
#(
   parameter int unsigned SCORE_LAT = 2,
   parameter int unsigned MAX_TX    = 16
) (
   input  logic              clk,
   input  logic              rst,
   trace_scheduler_if.slave  bus
);

   localparam int unsigned DRN_W = $clog2(SCORE_LAT + 2);

   state_t             state, state_d;
   logic               cur_id, cur_id_d;
   logic [CNT_W-1:0]   count, count_d;
   logic [TS_W-1:0]    prev_ts, prev_ts_d;
   logic               order_err, order_err_d;
   logic               trunc, trunc_d;
   logic [DRN_W-1:0]   drain_cnt, drain_cnt_d;

   logic               ready0_q, ready0_d, ready1_q, ready1_d;
   logic               eng_valid_q, eng_valid_d, eng_new_q, eng_new_d;
   logic [TS_W-1:0]    eng_ts_q, eng_ts_d;
   logic               eng_in_q, eng_in_d;
   logic [METH_W-1:0]  eng_meth_q, eng_meth_d;
   logic [VAL_W-1:0]   eng_val_q, eng_val_d;
   logic               res_valid_q, res_valid_d, res_id_q, res_id_d;
   logic [SCORE_W-1:0] res_score_q, res_score_d;
   logic [CNT_W-1:0]   res_count_q, res_count_d;
   logic               res_trunc_q, res_trunc_d, res_err_q, res_err_d;

   req_tx_t            sel_tx_c;
   logic               sel_valid_c, sel_ready_c, accept_c, handshake_c, grant_id_c;
   logic [CNT_W-1:0]   count_inc_c;

   assign sel_tx_c    = cur_id ? bus.req_1 : bus.req_0;
   assign sel_valid_c = cur_id ? bus.req_valid_1 : bus.req_valid_0;
   assign sel_ready_c = cur_id ? ready1_q : ready0_q;
   assign accept_c    = (state == STREAM) && sel_valid_c && sel_ready_c;
   assign handshake_c = (state == REPORT) && bus.res_ready;
   assign count_inc_c = count + CNT_W'(1);

   trace_rr_arbiter u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        ({bus.req_valid_1, bus.req_valid_0}),
      .advance    (handshake_c),
      .served_id  (cur_id),
      .grant_id_c (grant_id_c)
   );

   // Next-state and next-output logic; every register is computed here.
   always_comb begin
      state_d     = state;
      cur_id_d    = cur_id;
      count_d     = count;
      prev_ts_d   = prev_ts;
      order_err_d = order_err;
      trunc_d     = trunc;
      drain_cnt_d = drain_cnt;
      eng_valid_d = 1'b0;
      eng_new_d   = 1'b0;
      eng_ts_d    = eng_ts_q;
      eng_in_d    = eng_in_q;
      eng_meth_d  = eng_meth_q;
      eng_val_d   = eng_val_q;
      res_valid_d = res_valid_q;
      res_id_d    = res_id_q;
      res_score_d = res_score_q;
      res_count_d = res_count_q;
      res_trunc_d = res_trunc_q;
      res_err_d   = res_err_q;

      case (state)
         IDLE: begin
            if (bus.req_valid_0 || bus.req_valid_1) begin
               cur_id_d = grant_id_c;
               state_d  = STREAM;
            end
         end
         STREAM: begin
            if (accept_c) begin
               eng_valid_d = 1'b1;
               eng_ts_d    = sel_tx_c.ts;
               eng_in_d    = sel_tx_c.dir_in;
               eng_meth_d  = sel_tx_c.method;
               eng_val_d   = sel_tx_c.value;
               prev_ts_d   = sel_tx_c.ts;
               count_d     = count_inc_c;
               // Equal timestamps are legal; only a strict decrease flags.
               if ((count != '0) && (sel_tx_c.ts < prev_ts)) begin
                  order_err_d = 1'b1;
               end
               if (sel_tx_c.last || (count_inc_c == CNT_W'(MAX_TX))) begin
                  eng_new_d   = 1'b1;
                  trunc_d     = ~sel_tx_c.last;
                  drain_cnt_d = '0;
                  state_d     = DRAIN;
               end
            end
         end
         DRAIN: begin
            drain_cnt_d = drain_cnt + DRN_W'(1);
            if (drain_cnt == DRN_W'(SCORE_LAT)) begin
               res_valid_d = 1'b1;
               res_id_d    = cur_id;
               res_score_d = bus.eng_confidence_score;
               res_count_d = count;
               res_trunc_d = trunc;
               res_err_d   = order_err;
               state_d     = REPORT;
            end
         end
         REPORT: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               count_d     = '0;
               order_err_d = 1'b0;
               trunc_d     = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Ready is registered from the next state, so res_ready never reaches it combinationally.
      ready0_d = (state_d == STREAM) && !cur_id_d;
      ready1_d = (state_d == STREAM) && cur_id_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cur_id      <= 1'b0;
         count       <= '0;
         prev_ts     <= '0;
         order_err   <= 1'b0;
         trunc       <= 1'b0;
         drain_cnt   <= '0;
         ready0_q    <= 1'b0;
         ready1_q    <= 1'b0;
         eng_valid_q <= 1'b0;
         eng_new_q   <= 1'b0;
         eng_ts_q    <= '0;
         eng_in_q    <= 1'b0;
         eng_meth_q  <= '0;
         eng_val_q   <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= 1'b0;
         res_score_q <= '0;
         res_count_q <= '0;
         res_trunc_q <= 1'b0;
         res_err_q   <= 1'b0;
      end else begin
         state       <= state_d;
         cur_id      <= cur_id_d;
         count       <= count_d;
         prev_ts     <= prev_ts_d;
         order_err   <= order_err_d;
         trunc       <= trunc_d;
         drain_cnt   <= drain_cnt_d;
         ready0_q    <= ready0_d;
         ready1_q    <= ready1_d;
         eng_valid_q <= eng_valid_d;
         eng_new_q   <= eng_new_d;
         eng_ts_q    <= eng_ts_d;
         eng_in_q    <= eng_in_d;
         eng_meth_q  <= eng_meth_d;
         eng_val_q   <= eng_val_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_score_q <= res_score_d;
         res_count_q <= res_count_d;
         res_trunc_q <= res_trunc_d;
         res_err_q   <= res_err_d;
      end
   end

   assign bus.req_ready_0      = ready0_q;
   assign bus.req_ready_1      = ready1_q;
   assign bus.eng_valid        = eng_valid_q;
   assign bus.eng_new_wallet   = eng_new_q;
   assign bus.eng_time_stamp   = eng_ts_q;
   assign bus.eng_in           = eng_in_q;
   assign bus.eng_method_field = eng_meth_q;
   assign bus.eng_value        = eng_val_q;
   assign bus.res_valid        = res_valid_q;
   assign bus.res_id           = res_id_q;
   assign bus.res_score        = res_score_q;
   assign bus.res_count        = res_count_q;
   assign bus.res_trunc        = res_trunc_q;
   assign bus.res_order_err    = res_err_q;

endmodule

// File: tb/tb_trace_scheduler.sv
// Directed and randomized traces against a trace-level reference model.
module tb_trace_scheduler;
   import trace_sched_pkg::*;

   localparam int unsigned SCORE_LAT = 2;
   localparam int unsigned MAX_TX    = 16;
   localparam int unsigned TXW       = $bits(req_tx_t);

   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   trace_scheduler_if bus ();

   trace_scheduler #(.SCORE_LAT(SCORE_LAT), .MAX_TX(MAX_TX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit rr_ptr = 1'b0;
   logic [SCORE_W-1:0] score_hist [int];
   req_tx_t tx_q [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; a fresh engine score is presented every cycle.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      bus.eng_confidence_score = SCORE_W'($urandom);
      score_hist[cyc] = bus.eng_confidence_score;
   endtask

   function automatic req_tx_t mk_tx(input logic [TS_W-1:0] ts, input logic [METH_W-1:0] m,
                                     input bit last);
      req_tx_t t;
      t.ts     = ts;
      t.dir_in = 1'($urandom);
      t.method = m;
      t.value  = VAL_W'($urandom);
      t.last   = last;
      return t;
   endfunction

   function automatic req_tx_t rnd_tx();
      return req_tx_t'(TXW'({$urandom, $urandom}));
   endfunction

   task automatic drive(input bit id, input bit v, input req_tx_t t);
      if (id) begin
         bus.req_valid_1 = v;
         bus.req_1       = t;
      end else begin
         bus.req_valid_0 = v;
         bus.req_0       = t;
      end
   endtask

   function automatic bit ready_of(input bit id);
      return id ? bus.req_ready_1 : bus.req_ready_0;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_eng"}, 64'({bus.eng_valid, bus.eng_time_stamp, bus.eng_in, bus.eng_method_field,
                              bus.eng_value, bus.eng_new_wallet}), 64'd0);
      chk({tag, "_res"}, 64'({bus.res_valid, bus.res_id, bus.res_score, bus.res_count,
                              bus.res_trunc, bus.res_order_err, bus.req_ready_0, bus.req_ready_1}), 64'd0);
   endtask

   // Offer tx_q from requester id; model the trace close, flags and score timing.
   task automatic run_trace(input bit id, input bit other_busy, input int stall,
                            input bit rr_early, input int pause_pct);
      int      close_i = -1;
      int      exp_cnt;
      bit      exp_tr;
      bit      exp_err = 1'b0;
      int      acc = 0;
      int      issue_cyc = 0;
      int      budget = 0;
      int      w = 0;
      bit      v;
      bit      acc_now;
      req_tx_t t;

      for (int i = 0; i < tx_q.size(); i++)
         if (close_i < 0 && (tx_q[i].last || i == int'(MAX_TX) - 1)) close_i = i;
      exp_cnt = close_i + 1;
      exp_tr  = !tx_q[close_i].last;
      for (int i = 1; i <= close_i; i++)
         if (tx_q[i].ts < tx_q[i-1].ts) exp_err = 1'b1;

      bus.res_ready = rr_early;
      while (acc < exp_cnt && budget < 300) begin
         v = ($urandom_range(99) >= 32'(pause_pct));
         t = tx_q[acc];
         drive(id, v, t);
         drive(!id, other_busy, rnd_tx());
         if (pause_pct == 0 && acc > 0)
            chk("stream_ready", 64'(ready_of(id)), 64'd1);
         acc_now = v && ready_of(id);
         step();
         budget++;
         chk("eng_valid", 64'(bus.eng_valid), 64'(acc_now));
         chk("ready_other", 64'(ready_of(!id)), 64'd0);
         if (acc_now) begin
            chk("eng_fields", 64'({bus.eng_time_stamp, bus.eng_in, bus.eng_method_field, bus.eng_value}),
                64'({t.ts, t.dir_in, t.method, t.value}));
            chk("eng_new_wallet", 64'(bus.eng_new_wallet), 64'(acc == close_i));
            if (acc == close_i) issue_cyc = cyc;
            acc++;
         end
      end
      chk("trace_accepts", 64'(acc), 64'(exp_cnt));
      drive(0, 1'b0, rnd_tx());
      drive(1, 1'b0, rnd_tx());

      while (!bus.res_valid && w < 20) begin
         chk("drain_ready", 64'({bus.req_ready_0, bus.req_ready_1}), 64'd0);
         step();
         w++;
      end
      chk("res_valid", 64'(bus.res_valid), 64'd1);
      chk("res_latency", 64'(cyc), 64'(issue_cyc + int'(SCORE_LAT) + 1));
      chk("res_payload", 64'({bus.res_id, bus.res_count, bus.res_trunc, bus.res_order_err}),
          64'({id, CNT_W'(exp_cnt), exp_tr, exp_err}));
      chk("res_score", 64'(bus.res_score), 64'(score_hist[issue_cyc + int'(SCORE_LAT)]));

      if (!rr_early) begin
         for (int s = 0; s < stall; s++) begin
            drive(0, 1'b1, rnd_tx());
            drive(1, 1'b1, rnd_tx());
            step();
            chk("stall_valid", 64'(bus.res_valid), 64'd1);
            chk("stall_payload", 64'({bus.res_id, bus.res_count, bus.res_trunc, bus.res_order_err, bus.res_score}),
                64'({id, CNT_W'(exp_cnt), exp_tr, exp_err, score_hist[issue_cyc + int'(SCORE_LAT)]}));
            chk("stall_no_grant", 64'({bus.req_ready_0, bus.req_ready_1}), 64'd0);
         end
         bus.res_ready = 1'b1;
      end
      step();
      drive(0, 1'b0, rnd_tx());
      drive(1, 1'b0, rnd_tx());
      chk("res_drop", 64'(bus.res_valid), 64'd0);
      bus.res_ready = 1'b0;
      repeat (acc) void'(tx_q.pop_front());
      rr_ptr = !id;
   endtask

   initial begin
      logic [TS_W-1:0] ts;
      int acc;
      int len;
      int lastpos;
      bit id;

      rst = 1'b1;
      bus.res_ready = 1'b0;
      drive(0, 1'b0, '0);
      drive(1, 1'b1, rnd_tx());
      bus.eng_confidence_score = '0;
      repeat (3) step();
      chk_all_zero("reset");
      rst = 1'b0;

      // Requester 0, 14 ascending transactions, requester 1 waiting throughout.
      for (int i = 0; i < 14; i++)
         tx_q.push_back(mk_tx(TS_W'(32'h633DF61F + 32'(i)), 2'b10, i == 13));
      run_trace(0, 1'b1, 0, 1'b0, 0);

      // Requester 1, 17 transactions with no last: forced close at MAX_TX.
      for (int i = 0; i < 17; i++)
         tx_q.push_back(mk_tx(TS_W'(32'h10000000 + 32'(i * 3)), 2'($urandom), 1'b0));
      run_trace(1, 1'b0, 0, 1'b0, 0);
      chk("leftover", 64'(tx_q.size()), 64'd1);
      tx_q.push_back(mk_tx(TS_W'(32'h10000100), 2'b01, 1'b1));
      run_trace(1, 1'b0, 0, 1'b0, 0);

      // Equal, equal, then lower timestamp; result ready already high.
      tx_q.push_back(mk_tx(TS_W'(32'h63580000), 2'b00, 1'b0));
      tx_q.push_back(mk_tx(TS_W'(32'h63580000), 2'b01, 1'b0));
      tx_q.push_back(mk_tx(TS_W'(32'h63560000), 2'b10, 1'b0));
      tx_q.push_back(mk_tx(TS_W'(32'h63570000), 2'b11, 1'b1));
      run_trace(0, 1'b0, 0, 1'b1, 0);

      // Clean trace with pauses and result back-pressure for 10 cycles.
      for (int i = 0; i < 5; i++)
         tx_q.push_back(mk_tx(TS_W'(32'h63560000 + 32'(i)), 2'b11, i == 4));
      run_trace(1, 1'b0, 10, 1'b0, 30);

      // Reset as the fifth transaction is accepted: trace discarded.
      acc = 0;
      drive(0, 1'b1, mk_tx(TS_W'(32'h20000000), 2'b00, 1'b0));
      for (int b = 0; b < 40 && acc < 5; b++) begin
         if (bus.req_ready_0) acc++;
         if (acc < 5) step();
      end
      chk("rst_reach5", 64'(acc), 64'd5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(0, 1'b0, rnd_tx());
      chk_all_zero("mid_reset");
      rr_ptr = 1'b0;
      for (int b = 0; b < 8; b++) begin
         step();
         chk("no_result", 64'({bus.res_valid, bus.eng_valid}), 64'd0);
      end

      // Randomized traces.
      for (int r = 0; r < 6; r++) begin
         id      = 1'($urandom);
         len     = int'($urandom_range(1, 20));
         lastpos = int'($urandom_range(0, 32'(len)));
         if (lastpos == len && len < int'(MAX_TX)) lastpos = len - 1;
         ts = TS_W'($urandom);
         for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 7))
               0:       ts = ts - TS_W'($urandom_range(1, 5));
               1:       ts = ts;
               default: ts = ts + TS_W'($urandom_range(1, 9));
            endcase
            tx_q.push_back(mk_tx(ts, 2'($urandom), i == lastpos));
         end
         run_trace(id, (id == rr_ptr) && 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom), 20);
         tx_q.delete();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trace_scheduler.md
TRACE_SCHEDULER -- requirements
Module: trace_scheduler

Interface
REQ-001 Parameter SCORE_LAT, default 2: cycles from the last transaction's issue to the confidence_score capture.
REQ-002 Parameter MAX_TX, default 16: maximum transactions per wallet trace before forced close.
REQ-003 Ports clk (in, 1, rising-edge clock) and rst (in, 1, reset): one clock; reset is synchronous and active-high.
REQ-004 Per requester k in {0,1}, req_valid_k (in, 1): transaction offered.
REQ-005 req_ready_k (out, 1): transaction accepted when valid and ready are both high.
REQ-006 req_ts_k (in, 31), req_in_k (in, 1), req_method_k (in, 2), req_value_k (in, 20): transaction fields.
REQ-007 req_last_k (in, 1): final transaction of the wallet trace.
REQ-008 eng_valid (out, 1): tracing-engine sample strobe.
REQ-009 eng_time_stamp (out, 31), eng_in (out, 1), eng_method_field (out, 2), eng_value (out, 20), eng_new_wallet (out, 1): engine inputs.
REQ-010 eng_confidence_score (in, 7): engine result.
REQ-011 res_valid (out, 1) and res_ready (in, 1): result handshake.
REQ-012 res_id (out, 1), res_score (out, 7), res_count (out, 5), res_trunc (out, 1), res_order_err (out, 1): result payload.

Function
REQ-013 FSM states SHALL be IDLE, STREAM, DRAIN, REPORT.
REQ-014 IDLE: if any req_valid_k is high, grant by round-robin (pointer starts at 0; on a tie the pointer's requester wins), then go to STREAM; all req_ready low.
REQ-015 STREAM: req_ready of the granted requester only SHALL be high; the other requester's req_ready SHALL be low.
REQ-016 Each accepted transaction SHALL appear on the eng_* outputs with eng_valid=1 exactly one cycle after acceptance (registered).
REQ-017 eng_valid SHALL be 0 in cycles with no issue; eng_* fields SHALL hold their last values.
REQ-018 Wallet-atomic: no interleaving of requesters within one trace.
REQ-019 eng_new_wallet SHALL be 1 only with the issued transaction that closes the trace.
REQ-020 A trace closes on acceptance with req_last=1, or on acceptance of transaction number MAX_TX.
REQ-021 If the close is by MAX_TX and req_last=0, res_trunc SHALL be 1.
REQ-022 Transaction count is 5-bit, counts 1..MAX_TX, and never wraps.
REQ-023 res_order_err SHALL be set if any req_ts within the trace is strictly less than the previous one; equal timestamps are legal. It SHALL be sticky per trace.
REQ-024 After the close, the FSM goes to DRAIN. req_ready is low for SCORE_LAT cycles, then eng_confidence_score is captured into res_score, and the FSM goes to REPORT.
REQ-025 REPORT: res_valid=1 with stable payload until res_ready. On the handshake: go to IDLE, move the pointer to the other requester, and clear count and flags.
REQ-026 res_valid already high with res_ready high in the same cycle: the handshake completes; no combinational path from res_ready to req_ready.
REQ-027 req_valid dropping mid-trace SHALL pause STREAM without closing the trace; there is no timeout.
REQ-028 Close-to-close minimum throughput: one transaction per clock while streaming.

Reset
REQ-029 While rst=1 at a clk edge: state IDLE, pointer 0, all outputs 0 (eng_*, res_*, req_ready_*), count 0, flags 0.
REQ-030 Reset mid-trace SHALL discard the trace; no result is produced.

Structure
REQ-031 Package trace_sched_pkg: state enumeration, TS_W=31, VAL_W=20, METH_W=2, SCORE_W=7, CNT_W=5.
REQ-032 One sub-module, trace_rr_arbiter: 2-way round-robin with a registered pointer and an advance input. All else is inline.

Verification
REQ-033 Requester 0 sends 14 transactions (ts ascending from 0x633DF61F, method 2'b10), last on #14 -> 14 eng_valid pulses; eng_new_wallet=1 only on #14; res_id=0, res_count=14, res_trunc=0, res_score equals engine score SCORE_LAT cycles later.
REQ-034 Both requesters valid from reset -> requester 0 is served first, then requester 1; req_ready_1 is low throughout requester 0's trace.
REQ-035 Requester 1 sends 17 transactions with req_last never set -> close at #16 with res_trunc=1 and res_count=16; #17 starts a new trace after REPORT.
REQ-036 Two equal timestamps, then a lower one (0x6356... after 0x6358...) -> res_order_err=1; next trace res_order_err=0.
REQ-037 res_ready held low 10 cycles -> res_valid and payload stable, no new grant; rst pulse at transaction #5 -> all outputs 0 next cycle, no res_valid.
